// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and line-level constants (UART_TX_PARITY_EN adds PARITY)
// Shared by the transmitter and receiver so both agree on framing levels.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

`ifdef UART_TX_PARITY_EN
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter, pulses bit_end on the last cycle of each bit
// Counts 0..NCLKS_PER_BIT-1 while enabled; clear has priority and parks the count at 0.
module uart_baud_cnt #(
    parameter int NCLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = $clog2(NCLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = enable && !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with one-entry holding register; UART_TX_PARITY_EN adds a parity bit
// Frames are start, 8 data bits LSB first, optional parity, stop; the line level is registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int NCLKS_PER_BIT = 217,
    parameter int PARITY_ODD    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx_serial,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    generate
        if (NCLKS_PER_BIT < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
            $error("uart_tx: illegal parameter value");
        end
    endgenerate

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        serial_q, serial_d;
    logic        bit_end;
    logic        accept;
    logic        in_idle;
    logic        tx_done;

    assign in_idle = (state_q == ST_IDLE);
    assign accept  = i_tx_valid && !hold_full_q;

    uart_baud_cnt #(
        .NCLKS_PER_BIT(NCLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (in_idle),
        .enable (!in_idle),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_idx_d   = bit_idx_q;
        tx_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // An idle transmitter starts the frame directly, skipping the holding register.
                if (accept) begin
                    shift_d   = i_tx_data;
                    bit_idx_d = 3'd0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        bit_idx_d   = 3'd0;
                        state_d     = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Written after the drain so a same-edge write leaves the register full.
        if (accept && !in_idle) begin
            hold_d      = i_tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_comb begin
        serial_d = LINE_IDLE;
        case (state_d)
            ST_IDLE:   serial_d = LINE_IDLE;
            ST_START:  serial_d = START_BIT;
            ST_DATA:   serial_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: serial_d = parity_bit(shift_d, PARITY_ODD[0]);
`endif
            ST_STOP:   serial_d = STOP_BIT;
            default:   serial_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= '0;
            serial_q    <= LINE_IDLE;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_idx_q   <= bit_idx_d;
            serial_q    <= serial_d;
        end
    end

    assign o_tx_ready  = !hold_full_q;
    assign o_tx_serial = serial_q;
    assign o_tx_busy   = !in_idle;
    assign o_tx_done   = tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (parity checks when UART_TX_PARITY_EN is defined)
module tb_uart_tx;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = N * FB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_serial, tx_busy, tx_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(.NCLKS_PER_BIT(N), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_tx_serial(tx_serial), .o_tx_busy(tx_busy), .o_tx_done(tx_done)
    );

`ifdef UART_TX_PARITY_EN
    logic odd_ready, odd_serial, odd_busy, odd_done;
    uart_tx #(.NCLKS_PER_BIT(N), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(odd_ready), .o_tx_serial(odd_serial), .o_tx_busy(odd_busy), .o_tx_done(odd_done)
    );
`endif

    // Line level of bit slot idx (0 = start) of a frame carrying d.
    function automatic logic ref_bit(input logic [7:0] d, input int idx, input logic odd);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return (^d) ^ odd;
`endif
        return 1'b1;
    endfunction

    task automatic offer(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Starts in cycle 1 after a transfer edge; checks frames back-to-back, then idle.
    task automatic monitor_frames(input int nframes);
        logic [7:0] b;
        for (int f = 0; f < nframes; f++) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL exp_queue: got empty, want byte for frame %0d", f);
                return;
            end
            b = exp_q.pop_front();
            for (int k = 1; k <= FL; k++) begin
                @(negedge clk);
                n_cmp++;
                if (tx_serial !== ref_bit(b, (k-1)/N, 1'b0)) begin
                    n_bad++;
                    $display("FAIL serial byte=%h cycle=%0d: got %b want %b", b, k, tx_serial, ref_bit(b, (k-1)/N, 1'b0));
                end
                n_cmp++;
                if (tx_busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy byte=%h cycle=%0d: got %b want 1", b, k, tx_busy);
                end
                n_cmp++;
                if (tx_done !== (k == FL)) begin
                    n_bad++;
                    $display("FAIL done byte=%h cycle=%0d: got %b want %b", b, k, tx_done, (k == FL));
                end
`ifdef UART_TX_PARITY_EN
                n_cmp++;
                if (odd_serial !== ref_bit(b, (k-1)/N, 1'b1) || odd_done !== (k == FL)) begin
                    n_bad++;
                    $display("FAIL odd_frame byte=%h cycle=%0d: got serial %b done %b want %b %b",
                             b, k, odd_serial, odd_done, ref_bit(b, (k-1)/N, 1'b1), (k == FL));
                end
`endif
            end
        end
        @(negedge clk);
        n_cmp++;
        if (tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_after: got busy %b serial %b want 0 1", tx_busy, tx_serial);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({tx_serial, tx_busy, tx_done, tx_ready} !== 4'b1001) begin
            n_bad++;
            $display("FAIL reset_state: got serial/busy/done/ready %b want 1001", {tx_serial, tx_busy, tx_done, tx_ready});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom);
            exp_q.push_back(b);
            offer(b);
            monitor_frames(1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b1, b2;
        for (int it = 0; it < 2; it++) begin
            b1 = (it == 0) ? 8'h01 : 8'($urandom);
            b2 = (it == 0) ? 8'hFF : 8'($urandom);
            exp_q.push_back(b1);
            exp_q.push_back(b2);
            offer(b1);
            fork
                monitor_frames(2);
                begin
                    for (int k = 1; k <= 42; k++) begin
                        @(negedge clk);
                        if (k == 10) begin
                            n_cmp++;
                            if (tx_ready !== 1'b1) begin
                                n_bad++;
                                $display("FAIL b2b_ready_before: got %b want 1", tx_ready);
                            end
                            tx_valid = 1'b1;
                            tx_data  = b2;
                        end
                        if (k == 11) begin
                            tx_valid = 1'b0;
                            n_cmp++;
                            if (tx_ready !== 1'b0) begin
                                n_bad++;
                                $display("FAIL b2b_ready_fall: got %b want 0", tx_ready);
                            end
                        end
                        if (k == 40 || k == 41) begin
                            n_cmp++;
                            if (tx_ready !== (k == 41)) begin
                                n_bad++;
                                $display("FAIL b2b_ready_reload cycle=%0d: got %b want %b", k, tx_ready, (k == 41));
                            end
                        end
                    end
                end
            join
        end
    endtask

    task automatic test_hold_valid();
        int acc;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h3C);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        acc = (tx_ready === 1'b1) ? 1 : 0;
        @(posedge clk);
        fork
            monitor_frames(3);
            begin
                for (int k = 1; k <= 80; k++) begin
                    @(negedge clk);
                    if (k == 80) tx_valid = 1'b0;
                    else if (tx_ready === 1'b1) acc++;
                end
            end
        join
        n_cmp++;
        if (acc != 3) begin
            n_bad++;
            $display("FAIL hold_valid_accepts: got %0d want 3", acc);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        offer(8'h55);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 5) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
            end
            if (k == 6) begin
                tx_valid = 1'b0;
                n_cmp++;
                if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL mid_held: got ready %b busy %b want 0 1", tx_ready, tx_busy);
                end
            end
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx_serial, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            n_bad++;
            $display("FAIL mid_reset_async: got serial/ready/busy/done %b want 1100", {tx_serial, tx_ready, tx_busy, tx_done});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (tx_done !== 1'b0 || tx_serial !== 1'b1) begin
                n_bad++;
                $display("FAIL mid_reset_hold: got done %b serial %b want 0 1", tx_done, tx_serial);
            end
        end
        rst = 1'b0;
        b = 8'($urandom);
        exp_q.push_back(b);
        offer(b);
        monitor_frames(1);
    endtask

    task automatic test_idle_random();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            n_cmp++;
            if (tx_serial !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_random cycle=%0d: got serial %b done %b busy %b want 1 0 0", k, tx_serial, tx_done, tx_busy);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        exp_q.push_back(8'h07);
        offer(8'h07);
        monitor_frames(1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold_valid();
        test_reset_mid();
        test_idle_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter NCLKS_PER_BIT, default 217, giving clock cycles per bit (Fclk/baud, e.g. 25 MHz / 115200); legal range is 4 or more.
REQ-002 The block SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd; it is used only when UART_TX_PARITY_EN is defined.
REQ-003 Ports SHALL be as follows:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_tx_data  in  8  byte to send.
- i_tx_valid  in  1  byte offered.
- o_tx_ready  out  1  byte can be accepted.
- o_tx_serial  out  1  UART line, idle high.
- o_tx_busy  out  1  frame in progress.
- o_tx_done  out  1  one-cycle pulse at the end of each frame.

Function
REQ-004 A transfer SHALL occur on any rising clk edge where i_tx_valid=1 and o_tx_ready=1.
- i_tx_data is captured on that edge.
- i_tx_valid may be held with no further effect while o_tx_ready=0.
REQ-005 A one-entry holding register SHALL be provided; o_tx_ready SHALL equal NOT(holding register full).
REQ-006 The state machine SHALL have states IDLE, START, DATA, STOP, plus PARITY when UART_TX_PARITY_EN is defined.
REQ-007 A transfer in IDLE SHALL bypass the holding register and load the shift register directly.
- The state SHALL enter START on that same edge.
- o_tx_serial SHALL be low from that edge onward.
REQ-008 A transfer in any state other than IDLE SHALL write the holding register.
REQ-009 Each bit SHALL be driven for exactly NCLKS_PER_BIT cycles, timed by a counter that counts 0..NCLKS_PER_BIT-1 and then wraps to 0.
REQ-010 The frame SHALL be sent in this order:
- start bit, 0;
- data bits 0 to 7, LSB first, counted by a 3-bit index;
- parity bit, if enabled;
- stop bit, 1.
REQ-011 On the final cycle of STOP, o_tx_done SHALL pulse high for exactly 1 cycle.
- If the holding register is full, the FSM SHALL reload the shift register from it, clear the holding register and enter START, with no idle gap between frames.
- Otherwise the FSM SHALL enter IDLE.
REQ-012 If a transfer and a holding-register drain occur on the same edge, the new byte SHALL be written to the holding register and the holding register SHALL remain full.
REQ-013 o_tx_busy SHALL be 1 in every state except IDLE.
REQ-014 o_tx_serial SHALL be driven from a flop, with no combinational path from inputs.
REQ-015 Frame length SHALL be 10*NCLKS_PER_BIT cycles, or 11*NCLKS_PER_BIT with parity.
REQ-016 The sampled i_tx_data SHALL be ignored when i_tx_valid=0.

Reset
REQ-017 Asserting rst SHALL asynchronously force the following, without waiting for a clock edge:
- state IDLE;
- o_tx_serial=1, o_tx_busy=0, o_tx_done=0, o_tx_ready=1;
- holding register empty;
- bit counter and bit index cleared to 0.
REQ-018 Reset asserted mid-frame SHALL abort the frame with the line held high, and any held byte SHALL be discarded.
REQ-019 The first transfer SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-020 With macro UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA and drive one bit: XOR of the 8 data bits, XOR PARITY_ODD.
REQ-021 With UART_TX_PARITY_EN undefined, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-022 The state enum typedef and the constants for the idle line level (1) and start bit level (0) SHALL reside in package uart_pkg, shared with the receiver.
REQ-023 Bit-period timing SHALL be implemented in sub-module uart_baud_cnt.
- It is parameterised by NCLKS_PER_BIT.
- Counter width is $clog2(NCLKS_PER_BIT).
- It has inputs clear and enable, and outputs a one-cycle bit_end pulse.

Verification (NCLKS_PER_BIT=4)
REQ-024 Scenario: send 0xA5 from IDLE -> o_tx_serial reads 0,1,0,1,0,0,1,0,1,1, each level held for 4 cycles; o_tx_done is high on cycle 40 after the transfer; o_tx_busy is high for 40 cycles.
REQ-025 Scenario: send 0x01 then 0xFF while the first frame is in flight -> o_tx_ready falls after the second transfer; the 0xFF start bit follows the 0x01 stop bit with no gap; o_tx_ready rises at that reload.
REQ-026 Scenario: hold i_tx_valid=1 through two full frames with data 0x3C -> exactly one byte per frame is accepted, and frames run back-to-back at 40 cycles each.
REQ-027 Scenario: assert rst at cycle 15 of a frame for 0x55, with a byte held -> o_tx_serial=1 and o_tx_ready=1 immediately; no o_tx_done pulse; the next transfer starts a clean frame.
REQ-028 Scenario: with UART_TX_PARITY_EN defined, send 0x07 with PARITY_ODD=0 -> parity bit is 1 and the frame is 44 cycles; with PARITY_ODD=1 the parity bit is 0.
REQ-029 Scenario: i_tx_valid=0 with random i_tx_data for 100 cycles -> o_tx_serial stays at 1 and no o_tx_done pulse occurs.
